setmem_loop_sequencer: RTL and testbench
========================================

# setmem_loop_sequencer

Top-level control FSM for the setMem accelerator datapath. It accepts a block-level ap_ctrl_hs start/done handshake and runs the three pipelined loop sub-blocks (VITIS_LOOP_32_1, VITIS_LOOP_41_2, VITIS_LOOP_58_3) strictly in order. Each loop runs to completion before the next one is started. For each run it latches per-loop trip counts, skips loops whose trip count is zero, and records a per-loop cycle count for the dataflow/upc profiling monitors.

## Interface
- NUM_STAGES, 3, number of sequenced loop sub-blocks (stage 0 runs first)
- TRIP_W, 16, width of one trip count
- CNT_W, 32, width of one per-stage cycle counter
- clock  in  1  single design clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- ap_start  in  1  block start request (level)
- ap_ready  out  1  one-cycle pulse: inputs consumed, run complete
- ap_done  out  1  one-cycle pulse: all stages finished
- ap_idle  out  1  high only in IDLE
- trip_in  in  NUM_STAGES*TRIP_W  trip counts; stage i at bits [i*TRIP_W +: TRIP_W]
- child_start  out  NUM_STAGES  ap_start to each loop sub-block
- child_ready  in  NUM_STAGES  ap_ready from each loop sub-block
- child_done  in  NUM_STAGES  ap_done_int from each loop sub-block
- child_trip  out  NUM_STAGES*TRIP_W  latched trip counts driven to the sub-blocks
- cur_stage  out  $clog2(NUM_STAGES)  index of the active stage; 0 when idle
- stage_cycles  out  NUM_STAGES*CNT_W  per-stage busy-cycle counts from the last run

## Operation
- Reset values: ap_ready=0, ap_done=0, ap_idle=1, child_start=0, child_trip=0, cur_stage=0, stage_cycles=0. The FSM goes to IDLE.
- States and transitions:
  - IDLE: on ap_start=1, latch trip_in into child_trip and clear all stage_cycles. Go to LAUNCH(first i with trip≠0). If every trip count is 0, go to DONE.
  - LAUNCH(i): child_start[i]=1. Hold it until child_ready[i]=1 is sampled.
    - ready and child_done[i] in the same cycle: advance to the next nonzero stage, or to DONE if none remain.
    - ready without done: go to WAIT(i).
  - WAIT(i): child_start[i]=0. On child_done[i]=1, advance to the next nonzero stage, or to DONE.
  - DONE: ap_done=1 and ap_ready=1 for exactly one cycle, then IDLE.
- At most one child_start bit is ever high.
- child_ready/child_done from any stage other than the active one are ignored in every state. child_done in LAUNCH without child_ready is also ignored.
- ap_start is sampled only in IDLE. Dropping it mid-run has no effect. trip_in changes mid-run have no effect.
- stage_cycles[i] increments in every cycle the FSM is in LAUNCH(i) or WAIT(i), including the child_done cycle. It saturates at all-ones. It holds its value after the run and is cleared only at the next accepted start. Skipped stages read 0.
- cur_stage follows the FSM stage index in LAUNCH/WAIT. It holds the last stage in DONE and reads 0 in IDLE.

## Timing
- Cycle 0: IDLE samples ap_start=1. Cycle 1: LAUNCH of the first nonzero stage, child_start high.
- Stage handoff has zero bubble: if the stage i done cycle is cycle k, stage i+1 child_start is high in cycle k+1.
- DONE is the cycle after the last child_done. IDLE follows one cycle later. Back-to-back ap_start is accepted from that IDLE cycle, so there is a minimum of one idle cycle between runs.
- All-zero trip counts: DONE in cycle 1, ap_done pulse in cycle 1.
- Reset asserted mid-run: the next cycle shows reset values. child_start drops immediately, and no ap_done is issued.
- All outputs are registered or decoded from state only. There is no combinational path from child_* to child_start.

## Test plan
- Nominal run. Trips {8,4,6}. Each child asserts ready in its first LAUNCH cycle and done 4/2/5 cycles later.
  - Expected: child_start sequence 001→010→100 with no overlap or gap cycles. ap_done one cycle after stage 2 done. stage_cycles={5,3,6}.
- Skip stage. Trips {8,0,6}.
  - Expected: stage 1 is never started, stage 2 launches the cycle after stage 0 done, stage_cycles[1]=0.
- Empty run. Trips {0,0,0}.
  - Expected: ap_done=ap_ready=1 in cycle 1, child_start stays 0, ap_idle=1 again in cycle 2.
- Delayed ready with same-cycle ready+done. Stage 0 ready after 3 cycles; stage 1 ready and done together.
  - Expected: child_start[0] held 4 cycles. Stage 1 goes LAUNCH→next stage directly with stage_cycles[1]=1.
- Spurious and back-to-back. Inject child_done[2] during stage 0, then change trip_in and hold ap_start high through the run.
  - Expected: the spurious done is ignored and the latched trips are unchanged. A second run starts one cycle after ap_done, with the counters cleared at that start.
- Reset mid-WAIT(1).
  - Expected: the next cycle shows child_start=0, ap_idle=1, stage_cycles=0, and a later ap_start begins again at stage 0.

Source files
------------

// File: rtl/setmem_loop_sequencer.sv
// setmem_loop_sequencer: top-level control FSM for the setMem datapath.
// Runs the loop sub-blocks one after another under an ap_ctrl_hs handshake,
// skipping stages whose latched trip count is zero, and keeps a per-stage
// busy-cycle count for the profiling monitors.
//
// Ports:
//   clock, reset          design clock, synchronous active-high reset
//   ap_start              block start request (level, sampled only in IDLE)
//   ap_ready, ap_done     one-cycle pulses at the end of a run
//   ap_idle               high only while idle
//   trip_in               per-stage trip counts, latched at start
//   child_start           one-hot ap_start to the active loop sub-block
//   child_ready/done      handshake back from the loop sub-blocks
//   child_trip            latched trip counts driven to the sub-blocks
//   cur_stage             index of the active stage (0 when idle)
//   stage_cycles          per-stage busy-cycle counts from the last run
module setmem_loop_sequencer #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned TRIP_W     = 16,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned STAGE_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ap_start,
  output logic                         ap_ready,
  output logic                         ap_done,
  output logic                         ap_idle,
  input  logic [NUM_STAGES*TRIP_W-1:0] trip_in,
  output logic [NUM_STAGES-1:0]        child_start,
  input  logic [NUM_STAGES-1:0]        child_ready,
  input  logic [NUM_STAGES-1:0]        child_done,
  output logic [NUM_STAGES*TRIP_W-1:0] child_trip,
  output logic [STAGE_W-1:0]           cur_stage,
  output logic [NUM_STAGES*CNT_W-1:0]  stage_cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;

  logic               first_ok;
  logic [STAGE_W-1:0] first_idx;
  logic               nxt_ok;
  logic [STAGE_W-1:0] nxt_idx;
  logic [CNT_W-1:0]   cyc_cur;
  logic               act_ready;
  logic               act_done;

  function automatic logic [NUM_STAGES-1:0] onehot(input logic [STAGE_W-1:0] idx);
    return NUM_STAGES'(1) << idx;
  endfunction

  // Lowest nonzero stage of the incoming trips, and the next nonzero stage
  // after the active one among the latched trips.
  always_comb begin
    first_ok  = 1'b0;
    first_idx = '0;
    nxt_ok    = 1'b0;
    nxt_idx   = '0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if (trip_in[i*TRIP_W +: TRIP_W] != '0) begin
        first_ok  = 1'b1;
        first_idx = STAGE_W'(i);
      end
      if ((i > int'(cur_stage)) && (child_trip[i*TRIP_W +: TRIP_W] != '0)) begin
        nxt_ok  = 1'b1;
        nxt_idx = STAGE_W'(i);
      end
    end
  end

  // Only the active stage's handshake is ever looked at.
  assign act_ready = child_ready[cur_stage];
  assign act_done  = child_done[cur_stage];
  assign cyc_cur   = stage_cycles[cur_stage*CNT_W +: CNT_W];

  // Sequencer FSM; every output is updated alongside the state it belongs to.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      ap_ready     <= 1'b0;
      ap_done      <= 1'b0;
      ap_idle      <= 1'b1;
      child_start  <= '0;
      child_trip   <= '0;
      cur_stage    <= '0;
      stage_cycles <= '0;
    end else begin
      ap_ready <= 1'b0;
      ap_done  <= 1'b0;

      // Busy-cycle count for the active stage, saturating.
      if ((state == S_LAUNCH || state == S_WAIT) && (cyc_cur != {CNT_W{1'b1}})) begin
        stage_cycles[cur_stage*CNT_W +: CNT_W] <= cyc_cur + CNT_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (ap_start) begin
            child_trip   <= trip_in;
            stage_cycles <= '0;
            ap_idle      <= 1'b0;
            if (first_ok) begin
              state       <= S_LAUNCH;
              cur_stage   <= first_idx;
              child_start <= onehot(first_idx);
            end else begin
              state    <= S_DONE;
              ap_done  <= 1'b1;
              ap_ready <= 1'b1;
            end
          end
        end

        S_LAUNCH, S_WAIT: begin
          // A done in LAUNCH only counts when it arrives together with ready.
          if (act_done && (state == S_WAIT || act_ready)) begin
            if (nxt_ok) begin
              state       <= S_LAUNCH;
              cur_stage   <= nxt_idx;
              child_start <= onehot(nxt_idx);
            end else begin
              state       <= S_DONE;
              child_start <= '0;
              ap_done     <= 1'b1;
              ap_ready    <= 1'b1;
            end
          end else if (state == S_LAUNCH && act_ready) begin
            state       <= S_WAIT;
            child_start <= '0;
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          ap_idle   <= 1'b1;
          cur_stage <= '0;
        end

        default: begin
          state       <= S_IDLE;
          ap_idle     <= 1'b1;
          child_start <= '0;
          cur_stage   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_setmem_loop_sequencer.sv
// Scoreboard bench for setmem_loop_sequencer: stimulus pushes expected launch
// and completion events, a negedge monitor pops and compares them.
module tb_setmem_loop_sequencer;

  logic        clock;
  logic        reset;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_idle;
  logic [47:0] trip_in;
  logic [2:0]  child_start;
  logic [2:0]  child_ready;
  logic [2:0]  child_done;
  logic [47:0] child_trip;
  logic [1:0]  cur_stage;
  logic [95:0] stage_cycles;

  setmem_loop_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .trip_in     (trip_in),
    .child_start (child_start),
    .child_ready (child_ready),
    .child_done  (child_done),
    .child_trip  (child_trip),
    .cur_stage   (cur_stage),
    .stage_cycles(stage_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [2:0] oh;
    int         at;
    int         hold;
  } launch_t;

  typedef struct {
    int          at;
    logic [95:0] sc;
    logic [47:0] tr;
    logic [1:0]  cur;
  } done_t;

  launch_t lq[$];
  done_t   dq[$];

  task automatic push_l(input int stage, input int at, input int hold);
    launch_t e;
    e.oh   = 3'(1 << stage);
    e.at   = at;
    e.hold = hold;
    lq.push_back(e);
  endtask

  task automatic push_d(input int at, input logic [95:0] sc, input logic [47:0] tr,
                        input logic [1:0] cur);
    done_t e;
    e.at  = at;
    e.sc  = sc;
    e.tr  = tr;
    e.cur = cur;
    dq.push_back(e);
  endtask

  // Child sub-block model: ready rdy[s] cycles after its start is first seen,
  // done dd[s] cycles after ready; optional spurious done on stage 2.
  int rdy[3];
  int dd[3];
  int spur_at = -1;

  initial begin
    bit busy;
    int s;
    int t0;
    busy        = 1'b0;
    s           = 0;
    t0          = 0;
    child_ready = '0;
    child_done  = '0;
    forever begin
      @(posedge clock);
      #1;
      child_ready = '0;
      child_done  = '0;
      if (reset) begin
        busy = 1'b0;
      end else begin
        if (!busy && child_start != 3'b000) begin
          busy = 1'b1;
          t0   = cyc;
          s    = child_start[0] ? 0 : (child_start[1] ? 1 : 2);
        end
        if (busy) begin
          if (cyc == t0 + rdy[s]) child_ready[s] = 1'b1;
          if (cyc == t0 + rdy[s] + dd[s]) begin
            child_done[s] = 1'b1;
            busy          = 1'b0;
          end
        end
        if (cyc == spur_at) child_done[2] = 1'b1;
      end
    end
  end

  // Monitor: compares each new child_start value, its hold length, and each
  // ap_done pulse against the queued expectations.
  initial begin
    logic [2:0] prev_cs;
    launch_t    cur_l;
    done_t      cur_d;
    bit         have_l;
    int         hold_cnt;
    prev_cs  = 3'b000;
    have_l   = 1'b0;
    hold_cnt = 0;
    forever begin
      @(negedge clock);
      if (child_start != prev_cs) begin
        if (have_l && prev_cs != 3'b000) begin
          chk("start_hold", 128'(hold_cnt), 128'(cur_l.hold));
          have_l = 1'b0;
        end
        if (child_start != 3'b000) begin
          if (lq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_launch: got %b expected none (cycle %0d)", child_start, cyc);
          end else begin
            cur_l = lq.pop_front();
            chk("launch_onehot", 128'(child_start), 128'(cur_l.oh));
            chk("launch_cycle", 128'(cyc), 128'(cur_l.at));
            chk("launch_cur_stage", 128'(onehot_idx(child_start)), 128'(cur_stage));
            have_l   = 1'b1;
            hold_cnt = 1;
          end
        end
      end else if (child_start != 3'b000) begin
        hold_cnt++;
      end
      prev_cs = child_start;

      if (ap_done === 1'b1) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got ap_done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          cur_d = dq.pop_front();
          chk("done_cycle", 128'(cyc), 128'(cur_d.at));
          chk("done_ready", 128'(ap_ready), 128'(1));
          chk("done_idle", 128'(ap_idle), 128'(0));
          chk("done_stage_cycles", 128'(stage_cycles), 128'(cur_d.sc));
          chk("done_child_trip", 128'(child_trip), 128'(cur_d.tr));
          chk("done_cur_stage", 128'(cur_stage), 128'(cur_d.cur));
        end
      end
    end
  end

  function automatic int onehot_idx(input logic [2:0] v);
    return v[0] ? 0 : (v[1] ? 1 : 2);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((lq.size() != 0 || dq.size() != 0) && n < 200) begin
      tick(1);
      n++;
    end
    if (lq.size() != 0 || dq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d launches %0d dones pending expected 0", lq.size(), dq.size());
      lq.delete();
      dq.delete();
    end
    tick(2);
  endtask

  task automatic set_child(input int r0, input int r1, input int r2,
                           input int d0, input int d1, input int d2);
    rdy[0] = r0; rdy[1] = r1; rdy[2] = r2;
    dd[0]  = d0; dd[1]  = d1; dd[2]  = d2;
  endtask

  // Trips {8,4,6}, ready at launch, done 4/2/5 later -> cycles {5,3,6}.
  task automatic nominal_run();
    int s;
    set_child(0, 0, 0, 4, 2, 5);
    trip_in  = {16'd6, 16'd4, 16'd8};
    ap_start = 1'b1;
    s = cyc;
    push_l(0, s + 1, 1);
    push_l(1, s + 6, 1);
    push_l(2, s + 9, 1);
    push_d(s + 15, {32'd6, 32'd3, 32'd5}, {16'd6, 16'd4, 16'd8}, 2'd2);
    tick(1);
    ap_start = 1'b0;
    drain();
  endtask

  initial begin
    int s;
    reset    = 1'b1;
    ap_start = 1'b0;
    trip_in  = '0;
    set_child(0, 0, 0, 0, 0, 0);

    // Reset state
    tick(2);
    chk("rst_ap_idle", 128'(ap_idle), 128'(1));
    chk("rst_ap_done", 128'(ap_done), 128'(0));
    chk("rst_ap_ready", 128'(ap_ready), 128'(0));
    chk("rst_child_start", 128'(child_start), 128'(0));
    chk("rst_child_trip", 128'(child_trip), 128'(0));
    chk("rst_cur_stage", 128'(cur_stage), 128'(0));
    chk("rst_stage_cycles", 128'(stage_cycles), 128'(0));
    reset = 1'b0;
    tick(2);

    // Nominal run
    nominal_run();

    // Skip stage 1: trips {8,0,6}
    set_child(0, 0, 0, 4, 0, 5);
    trip_in  = {16'd6, 16'd0, 16'd8};
    ap_start = 1'b1;
    s = cyc;
    push_l(0, s + 1, 1);
    push_l(2, s + 6, 1);
    push_d(s + 12, {32'd6, 32'd0, 32'd5}, {16'd6, 16'd0, 16'd8}, 2'd2);
    tick(1);
    ap_start = 1'b0;
    drain();

    // Empty run: done in cycle 1, idle again in cycle 2
    trip_in  = '0;
    ap_start = 1'b1;
    s = cyc;
    push_d(s + 1, 96'd0, 48'd0, 2'd0);
    tick(1);
    ap_start = 1'b0;
    tick(1);
    chk("empty_idle_after", 128'(ap_idle), 128'(1));
    chk("empty_done_low", 128'(ap_done), 128'(0));
    drain();

    // Delayed ready on stage 0, same-cycle ready+done on stage 1
    set_child(3, 0, 0, 1, 0, 2);
    trip_in  = {16'd3, 16'd2, 16'd1};
    ap_start = 1'b1;
    s = cyc;
    push_l(0, s + 1, 4);
    push_l(1, s + 6, 1);
    push_l(2, s + 7, 1);
    push_d(s + 10, {32'd3, 32'd1, 32'd5}, {16'd3, 16'd2, 16'd1}, 2'd2);
    tick(1);
    ap_start = 1'b0;
    drain();

    // Spurious done, trip change mid-run, ap_start held -> back-to-back runs
    set_child(0, 0, 0, 3, 1, 2);
    trip_in  = {16'd4, 16'd3, 16'd2};
    ap_start = 1'b1;
    s = cyc;
    spur_at = s + 2;
    push_l(0, s + 1, 1);
    push_l(1, s + 5, 1);
    push_l(2, s + 7, 1);
    push_d(s + 10, {32'd3, 32'd2, 32'd4}, {16'd4, 16'd3, 16'd2}, 2'd2);
    push_l(0, s + 12, 1);
    push_l(1, s + 16, 1);
    push_l(2, s + 18, 1);
    push_d(s + 21, {32'd3, 32'd2, 32'd4}, {16'd7, 16'd7, 16'd7}, 2'd2);
    tick(3);
    trip_in = {16'd7, 16'd7, 16'd7};
    tick(9);
    chk("b2b_cycles_cleared", 128'(stage_cycles), 128'(0));
    chk("b2b_child_trip", 128'(child_trip), 128'({16'd7, 16'd7, 16'd7}));
    ap_start = 1'b0;
    spur_at  = -1;
    drain();

    // Reset during WAIT(1)
    set_child(0, 0, 0, 4, 2, 5);
    trip_in  = {16'd6, 16'd4, 16'd8};
    ap_start = 1'b1;
    s = cyc;
    push_l(0, s + 1, 1);
    push_l(1, s + 6, 1);
    tick(1);
    ap_start = 1'b0;
    tick(6);
    reset = 1'b1;
    tick(1);
    chk("midrst_child_start", 128'(child_start), 128'(0));
    chk("midrst_ap_idle", 128'(ap_idle), 128'(1));
    chk("midrst_stage_cycles", 128'(stage_cycles), 128'(0));
    chk("midrst_ap_done", 128'(ap_done), 128'(0));
    tick(1);
    reset = 1'b0;
    drain();

    // Restart after reset begins at stage 0
    nominal_run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
